// File: rtl/board_read_arbiter.sv
// rtl/board_read_arbiter.sv - board-memory read port arbiter: display priority, debug/scan round-robin, starvation steal
module board_read_arbiter #(
    parameter int ROW_W        = 3,
    parameter int COL_W        = 3,
    parameter int DATA_W       = 2,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ROW_W-1:0]  vid_row,
    input  logic [COL_W-1:0]  vid_col,
    output logic              vid_valid,
    output logic              vid_miss,
    output logic [DATA_W-1:0] vid_data,
    input  logic              dbg_req,
    input  logic [ROW_W-1:0]  dbg_row,
    input  logic [COL_W-1:0]  dbg_col,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              scan_req,
    input  logic [ROW_W-1:0]  scan_row,
    input  logic [COL_W-1:0]  scan_col,
    output logic              scan_ack,
    output logic [DATA_W-1:0] scan_data,
    output logic              mem_rd_en,
    output logic [ROW_W-1:0]  mem_row,
    output logic [COL_W-1:0]  mem_col,
    input  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_DBG, SRC_SCAN} src_t;

    src_t             grant;
    logic             steal;
    logic             dbg_elig, scan_elig, dbg_starved, scan_starved;
    logic             dbg_pend, scan_pend, rr_scan;
    logic [7:0]       dbg_wait, scan_wait;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    src_t             tag_q  [MEM_LAT];
    logic             miss_q [MEM_LAT];
    src_t             tag_out;
    logic             miss_out;

    assign tag_out  = tag_q[MEM_LAT-1];
    assign miss_out = miss_q[MEM_LAT-1];

    always_comb begin
        dbg_elig     = dbg_req && !dbg_pend && !dbg_ack;
        scan_elig    = scan_req && !scan_pend && !scan_ack;
        dbg_starved  = dbg_elig && (dbg_wait >= 8'(STARVE_LIMIT));
        scan_starved = scan_elig && (scan_wait >= 8'(STARVE_LIMIT));
        grant        = SRC_NONE;
        if (rst)
            grant = SRC_NONE;
        else if (dbg_starved && scan_starved)
            grant = rr_scan ? SRC_SCAN : SRC_DBG;
        else if (dbg_starved)
            grant = SRC_DBG;
        else if (scan_starved)
            grant = SRC_SCAN;
        else if (vid_req)
            grant = SRC_VID;
        else if (dbg_elig && scan_elig)
            grant = rr_scan ? SRC_SCAN : SRC_DBG;
        else if (dbg_elig)
            grant = SRC_DBG;
        else if (scan_elig)
            grant = SRC_SCAN;
        // a secondary can only beat a requesting display by being starved
        steal     = vid_req && (grant == SRC_DBG || grant == SRC_SCAN);
        mem_rd_en = (grant != SRC_NONE);
        case (grant)
            SRC_VID:  begin mem_row = vid_row;  mem_col = vid_col;  end
            SRC_DBG:  begin mem_row = dbg_row;  mem_col = dbg_col;  end
            SRC_SCAN: begin mem_row = scan_row; mem_col = scan_col; end
            default:  begin mem_row = row_q;    mem_col = col_q;    end
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            vid_valid <= 1'b0;
            vid_miss  <= 1'b0;
            vid_data  <= '0;
            dbg_ack   <= 1'b0;
            dbg_data  <= '0;
            scan_ack  <= 1'b0;
            scan_data <= '0;
            dbg_pend  <= 1'b0;
            scan_pend <= 1'b0;
            dbg_wait  <= '0;
            scan_wait <= '0;
            rr_scan   <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i]  <= SRC_NONE;
                miss_q[i] <= 1'b0;
            end
        end else begin
            row_q     <= mem_row;
            col_q     <= mem_col;
            tag_q[0]  <= grant;
            miss_q[0] <= steal;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i]  <= tag_q[i-1];
                miss_q[i] <= miss_q[i-1];
            end

            vid_valid <= (tag_out == SRC_VID);
            vid_miss  <= miss_out;
            dbg_ack   <= (tag_out == SRC_DBG);
            scan_ack  <= (tag_out == SRC_SCAN);
            if (tag_out == SRC_VID)  vid_data  <= mem_data;
            if (tag_out == SRC_DBG)  dbg_data  <= mem_data;
            if (tag_out == SRC_SCAN) scan_data <= mem_data;

            if (grant == SRC_DBG)       dbg_pend <= 1'b1;
            else if (tag_out == SRC_DBG) dbg_pend <= 1'b0;
            if (grant == SRC_SCAN)       scan_pend <= 1'b1;
            else if (tag_out == SRC_SCAN) scan_pend <= 1'b0;

            if (!dbg_req || grant == SRC_DBG)
                dbg_wait <= '0;
            else if (dbg_elig && dbg_wait != 8'hFF)
                dbg_wait <= dbg_wait + 8'd1;
            if (!scan_req || grant == SRC_SCAN)
                scan_wait <= '0;
            else if (scan_elig && scan_wait != 8'hFF)
                scan_wait <= scan_wait + 8'd1;

            if (grant == SRC_DBG)       rr_scan <= 1'b1;
            else if (grant == SRC_SCAN) rr_scan <= 1'b0;
        end
    end

endmodule

// File: tb/tb_board_read_arbiter.sv
// tb/tb_board_read_arbiter.sv - randomized and directed check of board_read_arbiter at MEM_LAT 1 and 3
module tb_board_read_arbiter;

    localparam int N      = 4096;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       vid_req = 1'b0, dbg_req = 1'b0, scan_req = 1'b0;
    logic [2:0] vid_row = '0, vid_col = '0, dbg_row = '0, dbg_col = '0, scan_row = '0, scan_col = '0;

    logic [1:0] rd, vv, vm, da, sa;
    logic [2:0] mr [2];
    logic [2:0] mc [2];
    logic [1:0] vd [2];
    logic [1:0] dd [2];
    logic [1:0] sd [2];
    logic [1:0] md [2];
    logic [1:0] board [64];
    logic [5:0] h1;
    logic [5:0] h3 [3];

    board_read_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(STARVE)) u_l1 (
        .clk_25MHz(clk), .rst(rst),
        .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
        .vid_valid(vv[0]), .vid_miss(vm[0]), .vid_data(vd[0]),
        .dbg_req(dbg_req), .dbg_row(dbg_row), .dbg_col(dbg_col),
        .dbg_ack(da[0]), .dbg_data(dd[0]),
        .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
        .scan_ack(sa[0]), .scan_data(sd[0]),
        .mem_rd_en(rd[0]), .mem_row(mr[0]), .mem_col(mc[0]), .mem_data(md[0]));

    board_read_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(STARVE)) u_l3 (
        .clk_25MHz(clk), .rst(rst),
        .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
        .vid_valid(vv[1]), .vid_miss(vm[1]), .vid_data(vd[1]),
        .dbg_req(dbg_req), .dbg_row(dbg_row), .dbg_col(dbg_col),
        .dbg_ack(da[1]), .dbg_data(dd[1]),
        .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
        .scan_ack(sa[1]), .scan_data(sd[1]),
        .mem_rd_en(rd[1]), .mem_row(mr[1]), .mem_col(mc[1]), .mem_data(md[1]));

    // board store: contents are static, data appears MEM_LAT cycles after the address
    always @(posedge clk) begin
        h1    <= {mr[0], mc[0]};
        h3[0] <= {mr[1], mc[1]};
        h3[1] <= h3[0];
        h3[2] <= h3[1];
    end
    assign md[0] = board[h1];
    assign md[1] = board[h3[2]];

    int n_cmp = 0, n_bad = 0, t = 0;

    bit         e_vv [2][N];
    bit         e_vm [2][N];
    bit         e_da [2][N];
    bit         e_sa [2][N];
    logic [1:0] e_vd [2][N];
    logic [1:0] e_dd [2][N];
    logic [1:0] e_sd [2][N];
    logic [1:0] cur_vd [2];
    logic [1:0] cur_dd [2];
    logic [1:0] cur_sd [2];
    int         busy  [2][2];
    int         waitc [2][2];
    int         rrp   [2];
    logic [2:0] last_r [2];
    logic [2:0] last_c [2];

    bit         o_rd [2][N];
    bit         o_vv [2][N];
    bit         o_vm [2][N];
    bit         o_da [2][N];
    bit         o_sa [2][N];
    logic [2:0] o_row [2][N];
    logic [2:0] o_col [2][N];
    logic [1:0] o_vd [2][N];
    logic [1:0] o_dd [2][N];

    task automatic chk(string nm, int inst, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", nm, inst, t, act, exp);
        end
    endtask

    task automatic model_reset(int i);
        for (int s = 0; s < 2; s++) begin
            busy[i][s]  = -100;
            waitc[i][s] = 0;
        end
        rrp[i]    = 0;
        last_r[i] = '0;
        last_c[i] = '0;
        cur_vd[i] = '0;
        cur_dd[i] = '0;
        cur_sd[i] = '0;
    endtask

    // Per-secondary "busy until ack cycle" windows and a schedule of expected responses
    task automatic model_cycle(int i);
        int         lat = (i == 0) ? 1 : 3;
        int         k, w;
        bit         el [2];
        bit         st [2];
        bit         rq [2];
        logic [2:0] ar [2];
        logic [2:0] ac [2];
        logic [2:0] er, ec;

        if (e_vv[i][t]) cur_vd[i] = e_vd[i][t];
        if (e_da[i][t]) cur_dd[i] = e_dd[i][t];
        if (e_sa[i][t]) cur_sd[i] = e_sd[i][t];
        chk("vid_valid", i, int'(vv[i]), int'(e_vv[i][t]));
        chk("vid_miss",  i, int'(vm[i]), int'(e_vm[i][t]));
        chk("vid_data",  i, int'(vd[i]), int'(cur_vd[i]));
        chk("dbg_ack",   i, int'(da[i]), int'(e_da[i][t]));
        chk("dbg_data",  i, int'(dd[i]), int'(cur_dd[i]));
        chk("scan_ack",  i, int'(sa[i]), int'(e_sa[i][t]));
        chk("scan_data", i, int'(sd[i]), int'(cur_sd[i]));

        rq[0] = dbg_req;  ar[0] = dbg_row;  ac[0] = dbg_col;
        rq[1] = scan_req; ar[1] = scan_row; ac[1] = scan_col;
        for (int s = 0; s < 2; s++) begin
            el[s] = !rst && rq[s] && (t > busy[i][s]);
            st[s] = el[s] && (waitc[i][s] >= STARVE);
        end
        if (st[0] && st[1])       w = rrp[i];
        else if (st[0])           w = 0;
        else if (st[1])           w = 1;
        else if (!rst && vid_req) w = 2;
        else if (el[0] && el[1])  w = rrp[i];
        else if (el[0])           w = 0;
        else if (el[1])           w = 1;
        else                      w = -1;

        if (w == 2)      begin er = vid_row; ec = vid_col; end
        else if (w >= 0) begin er = ar[w];   ec = ac[w];   end
        else             begin er = last_r[i]; ec = last_c[i]; end
        chk("mem_rd_en", i, int'(rd[i]), (w >= 0) ? 1 : 0);
        chk("mem_row",   i, int'(mr[i]), int'(er));
        chk("mem_col",   i, int'(mc[i]), int'(ec));

        o_rd[i][t] = rd[i]; o_vv[i][t] = vv[i]; o_vm[i][t] = vm[i];
        o_da[i][t] = da[i]; o_sa[i][t] = sa[i];
        o_row[i][t] = mr[i]; o_col[i][t] = mc[i];
        o_vd[i][t] = vd[i]; o_dd[i][t] = dd[i];

        last_r[i] = er;
        last_c[i] = ec;
        k = t + lat + 1;
        if (w == 2) begin
            e_vv[i][k] = 1'b1;
            e_vd[i][k] = board[{er, ec}];
        end else if (w >= 0) begin
            if (w == 0) begin e_da[i][k] = 1'b1; e_dd[i][k] = board[{er, ec}]; end
            else        begin e_sa[i][k] = 1'b1; e_sd[i][k] = board[{er, ec}]; end
            busy[i][w] = k;
            rrp[i]     = 1 - w;
            if (vid_req) e_vm[i][k] = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
            if (!rq[s] || w == s) waitc[i][s] = 0;
            else if (el[s] && waitc[i][s] < 255) waitc[i][s]++;
        end

        if (rst) begin
            for (int j = t + 1; j <= t + 5; j++) begin
                e_vv[i][j] = 1'b0; e_vm[i][j] = 1'b0;
                e_da[i][j] = 1'b0; e_sa[i][j] = 1'b0;
            end
            model_reset(i);
        end
    endtask

    task automatic step();
        #4;
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic set_in(bit vr, int vrw, int vcl, bit dr, int drw, int dcl, bit sr, int srw, int scl);
        vid_req  = vr; vid_row  = 3'(vrw); vid_col  = 3'(vcl);
        dbg_req  = dr; dbg_row  = 3'(drw); dbg_col  = 3'(dcl);
        scan_req = sr; scan_row = 3'(srw); scan_col = 3'(scl);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int b;

    initial begin
        for (int a = 0; a < 64; a++) board[a] = 2'(a % 3);
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // display only
        b = t;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 7, 7, 0, 0, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
        chk("A_rd0", 0, int'(o_rd[0][b]), 1);
        chk("A_rd2", 0, int'(o_rd[0][b+2]), 1);
        chk("A_vv2", 0, int'(o_vv[0][b+2]), 1);
        chk("A_vd3", 0, int'(o_vd[0][b+3]), 1);
        chk("A_vv4", 0, int'(o_vv[0][b+4]), 1);
        chk("A_vd4", 0, int'(o_vd[0][b+4]), 0);
        chk("A_vv5", 0, int'(o_vv[0][b+5]), 0);
        chk("A_l3_vv3", 1, int'(o_vv[1][b+3]), 0);
        chk("A_l3_vv4", 1, int'(o_vv[1][b+4]), 1);
        chk("A_l3_vd5", 1, int'(o_vd[1][b+5]), 1);

        // debug in a display gap
        do_reset();
        b = t;
        repeat (10) step();
        set_in(0, 0, 0, 1, 3, 5, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
        chk("B_rd10", 0, int'(o_rd[0][b+10]), 1);
        chk("B_row10", 0, int'(o_row[0][b+10]), 3);
        chk("B_col10", 0, int'(o_col[0][b+10]), 5);
        chk("B_ack11", 0, int'(o_da[0][b+11]), 0);
        chk("B_ack12", 0, int'(o_da[0][b+12]), 1);
        chk("B_dat12", 0, int'(o_dd[0][b+12]), 2);
        chk("B_ack13", 0, int'(o_da[0][b+13]), 0);
        chk("B_l3_ack12", 1, int'(o_da[1][b+12]), 0);
        chk("B_l3_ack14", 1, int'(o_da[1][b+14]), 1);

        // round-robin between debug and scan
        do_reset();
        b = t;
        set_in(0, 0, 0, 1, 1, 2, 1, 4, 6); repeat (9) step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
        chk("C_rd0", 0, int'(o_rd[0][b]), 1);
        chk("C_row0", 0, int'(o_row[0][b]), 1);
        chk("C_row1", 0, int'(o_row[0][b+1]), 4);
        chk("C_rd2", 0, int'(o_rd[0][b+2]), 0);
        chk("C_ack2", 0, int'(o_da[0][b+2]), 1);
        chk("C_row3", 0, int'(o_row[0][b+3]), 1);
        chk("C_sack3", 0, int'(o_sa[0][b+3]), 1);
        chk("C_row4", 0, int'(o_row[0][b+4]), 4);

        // scan starves under continuous display traffic
        do_reset();
        b = t;
        for (int k = 0; k < 14; k++) begin
            set_in(1, k % 8, (k + 1) % 8, 0, 0, 0, k <= 8, 2, 3);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
        chk("D_row8", 0, int'(o_row[0][b+8]), 2);
        chk("D_col8", 0, int'(o_col[0][b+8]), 3);
        chk("D_vv9", 0, int'(o_vv[0][b+9]), 1);
        chk("D_sack9", 0, int'(o_sa[0][b+9]), 0);
        chk("D_miss10", 0, int'(o_vm[0][b+10]), 1);
        chk("D_sack10", 0, int'(o_sa[0][b+10]), 1);
        chk("D_vv10", 0, int'(o_vv[0][b+10]), 0);
        chk("D_vv11", 0, int'(o_vv[0][b+11]), 1);
        chk("D_l3_miss12", 1, int'(o_vm[1][b+12]), 1);

        // withdrawal while display is busy, then reset after a debug grant
        do_reset();
        b = t;
        for (int k = 0; k < 14; k++) begin
            set_in(k < 10, k % 8, 0, k == 0, 5, 5, 0, 0, 0);
            step();
        end
        for (int k = 0; k < 14; k++) begin
            chk("E_noack", 0, int'(o_da[0][b+k]), 0);
            chk("E_noack", 1, int'(o_da[1][b+k]), 0);
        end
        b = t;
        set_in(0, 0, 0, 1, 6, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; step();
        rst = 1'b0; repeat (5) step();
        chk("E_rd0", 0, int'(o_rd[0][b]), 1);
        chk("E_row0", 0, int'(o_row[0][b]), 6);
        chk("E_ack2", 0, int'(o_da[0][b+2]), 0);
        chk("E_row2", 0, int'(o_row[0][b+2]), 0);
        chk("E_vv2", 0, int'(o_vv[0][b+2]), 0);
        chk("E_l3_ack4", 1, int'(o_da[1][b+4]), 0);

        // randomized traffic
        for (int k = 0; k < 2400; k++) begin
            int dens;
            dens = (k / 64) % 4;
            vid_req = (dens == 3) ? 1'b1 : (dens == 0) ? 1'b0 : ($urandom_range(9, 0) < (dens == 1 ? 5 : 9));
            vid_row = 3'($urandom);
            vid_col = 3'($urandom);
            if (!dbg_req) begin
                if ($urandom_range(3, 0) == 0) begin
                    dbg_req = 1'b1; dbg_row = 3'($urandom); dbg_col = 3'($urandom);
                end
            end else if ($urandom_range(15, 0) == 0) dbg_req = 1'b0;
            if (!scan_req) begin
                if ($urandom_range(3, 0) == 0) begin
                    scan_req = 1'b1; scan_row = 3'($urandom); scan_col = 3'($urandom);
                end
            end else if ($urandom_range(15, 0) == 0) scan_req = 1'b0;
            rst = ($urandom_range(599, 0) == 0);
            step();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
